ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the FPGA to the attached keyboard. It drives the shared ps2_clk/ps2_data lines open-drain using the standard inhibit/request-to-send sequence, shifts out data, odd parity and stop on device-generated clock edges, then checks the device ACK bit. It sits beside the keyboard receiver and asserts `rx_inhibit` so the receiver ignores the device clock edges it produces during a host transmission.

---
 rtl/ps2_host_tx.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain clk/data, ACK check).
// Optional feature: define PS2_TX_RESEND_EN for one automatic resend on NACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES    = 5000,
    parameter int START_HOLD_CYCLES = 50,
    parameter int TIMEOUT_CYCLES    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       err,
    output logic       err_timeout
);

    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(START_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_SAT   = {TW{1'b1}};

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE
    } state_t;

    state_t        state, state_nx;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_s, data_s, fall;
    logic          lines_high, high_d;
    logic [9:0]    frame;
    logic [3:0]    bit_idx;
    logic [3:0]    sel;
    logic          cur_bit;
    logic [TW-1:0] timer;
    logic          timeout;
    logic          nack;
    logic          load, tmr_clr, idx_clr, idx_inc, ack_take;
`ifdef PS2_TX_RESEND_EN
    logic          retried, retry_set;
`endif

    assign clk_s      = clk_sync[1];
    assign data_s     = data_sync[1];
    assign fall       = clk_sync[2] & ~clk_sync[1];
    assign lines_high = clk_s & data_s;
    assign timeout    = (timer >= TO_LIM);
    assign tx_ready   = (state == IDLE);
    assign rx_inhibit = (state != IDLE);

    // bit_idx counts device falls; 0 means the start bit is still on the line
    assign sel     = bit_idx - 4'd1;
    assign cur_bit = (bit_idx == 4'd0) ? 1'b0 : frame[sel];

    // Synchronise the asynchronous PS/2 lines (idle level is high)
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Frame, bit index, saturating timer and ACK result
    always_ff @(posedge clk) begin
        if (rst) begin
            frame   <= '0;
            bit_idx <= '0;
            timer   <= '0;
            nack    <= 1'b0;
            high_d  <= 1'b0;
        end else begin
            high_d <= lines_high;
            if (load) frame <= {1'b1, ~^tx_data, tx_data};
            if (tmr_clr)               timer <= '0;
            else if (timer != TMR_SAT) timer <= timer + 1'b1;
            if (idx_clr)      bit_idx <= '0;
            else if (idx_inc) bit_idx <= bit_idx + 4'd1;
            if (ack_take) nack <= data_s;
        end
    end

`ifdef PS2_TX_RESEND_EN
    // One-shot resend flag, cleared whenever the transmitter is idle
    always_ff @(posedge clk) begin
        if (rst)                retried <= 1'b0;
        else if (state == IDLE) retried <= 1'b0;
        else if (retry_set)     retried <= 1'b1;
    end
`endif

    // Next-state, line drive and result pulses
    always_comb begin
        state_nx    = state;
        load        = 1'b0;
        tmr_clr     = 1'b0;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        ack_take    = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        err_timeout = 1'b0;
`ifdef PS2_TX_RESEND_EN
        retry_set   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    load     = 1'b1;
                    tmr_clr  = 1'b1;
                    idx_clr  = 1'b1;
                    state_nx = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (timer == INH_LAST) begin
                    tmr_clr  = 1'b1;
                    state_nx = RTS;
                end
            end
            RTS: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                if (timer == HOLD_LAST) begin
                    tmr_clr  = 1'b1;
                    idx_clr  = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                ps2_data_oe = ~cur_bit;
                if (fall) begin
                    tmr_clr = 1'b1;
                    if (bit_idx == 4'd9) state_nx = ACK;
                    else                 idx_inc  = 1'b1;
                end else if (timeout) begin
                    ps2_data_oe = 1'b0;
                    err         = 1'b1;
                    err_timeout = 1'b1;
                    state_nx    = IDLE;
                end
            end
            ACK: begin
                if (fall) begin
                    ack_take = 1'b1;
                    tmr_clr  = 1'b1;
                    state_nx = WAIT_IDLE;
                end else if (timeout) begin
                    err         = 1'b1;
                    err_timeout = 1'b1;
                    state_nx    = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (lines_high && high_d) begin
                    if (!nack) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end else begin
`ifdef PS2_TX_RESEND_EN
                        if (!retried) begin
                            retry_set = 1'b1;
                            tmr_clr   = 1'b1;
                            state_nx  = INHIBIT;
                        end else begin
                            err      = 1'b1;
                            state_nx = IDLE;
                        end
`else
                        err      = 1'b1;
                        state_nx = IDLE;
`endif
                    end
                end else if (timeout) begin
                    err         = 1'b1;
                    err_timeout = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised bench for ps2_host_tx with a behavioural PS/2 device model.
// Frame contents are predicted from the byte alone (start, data, odd parity, stop).
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int HOLD = 8;
    localparam int TO   = 300;
`ifdef PS2_TX_RESEND_EN
    localparam bit RESEND = 1'b1;
`else
    localparam bit RESEND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit;
    logic       done, err, err_timeout;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_HOLD_CYCLES(HOLD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .rx_inhibit(rx_inhibit),
        .done(done),
        .err(err),
        .err_timeout(err_timeout)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame as seen at device rising edges: start, data LSB first, odd parity, stop
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int  ones;
        logic par;
        ones = $countones(b);
        par  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b, 1'b0};
    endfunction

    int cyc = 0, done_cnt = 0, err_cnt = 0, errto_cnt = 0, both_cnt = 0;
    int rel_cyc = 0, err_cyc = 0, err_oe = 0;
    int inh_len = 0, hold_len = 0, frames = 0, gap = 0, last_gap = 0;
    int inh_viol = 0;
    bit prev_clk_oe = 1'b0, prev_rxi = 1'b0;

    // Observe outputs mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) begin
            err_cnt++;
            if (err_timeout === 1'b1) errto_cnt++;
            err_cyc = cyc;
            err_oe  = int'(ps2_clk_oe | ps2_data_oe);
        end
        if (done === 1'b1 && err === 1'b1) both_cnt++;
        if (prev_clk_oe && ps2_clk_oe === 1'b0) rel_cyc = cyc;
        if (rx_inhibit === 1'b1 && !prev_rxi) begin
            frames++;
            last_gap = gap;
            inh_len  = 0;
            hold_len = 0;
        end
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh_len++;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) hold_len++;
        if (done === 1'b1)            gap = 0;
        else if (rx_inhibit === 1'b0) gap++;
        if ((ps2_clk_oe === 1'b1 || ps2_data_oe === 1'b1) &&
            rx_inhibit !== 1'b1) inh_viol++;
        prev_clk_oe = (ps2_clk_oe === 1'b1);
        prev_rxi    = (rx_inhibit === 1'b1);
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device: wait for request-to-send, then clock the frame and answer ACK/NACK
    task automatic device_xfer(input int half, input bit clock_it,
                               input bit ack, input int stop_after,
                               output logic [10:0] bits);
        int n;
        bit seen, released;
        bits = '0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        n = 0;
        seen = 1'b0;
        released = 1'b0;
        while (!released && n < INH + HOLD + 400) begin
            @(negedge clk);
            n++;
            if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) seen = 1'b1;
            else if (seen && ps2_clk_oe === 1'b0) released = 1'b1;
        end
        check("rts_release", {31'd0, released}, 32'd1);
        if (!released) return;
        bits[0] = ps2_data;
        if (!clock_it) return;
        for (int k = 1; k <= 11; k++) begin
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b1;
            if (k == stop_after) return;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k] = ps2_data;
            if (k == 10) dev_data_low = ack;
            if (k == 11) dev_data_low = 1'b0;
        end
    endtask

    task automatic settle(input int d0, input int e0);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack,
                             input bit ack2, input int half);
        logic [10:0] bits;
        int d0, e0, t0;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        t0 = errto_cnt;
        send(b);
        device_xfer(half, 1'b1, ack, 0, bits);
        check("frame_bits", {21'd0, bits}, {21'd0, frame_of(b)});
        ok = ack;
        if (!ack && RESEND) begin
            device_xfer(half, 1'b1, ack2, 0, bits);
            check("resend_bits", {21'd0, bits}, {21'd0, frame_of(b)});
            ok = ack2;
        end
        settle(d0, e0);
        check("done_pulses", done_cnt - d0, {31'd0, ok});
        check("err_pulses", err_cnt - e0, {31'd0, !ok});
        check("err_to_pulses", errto_cnt - t0, 32'd0);
    endtask

    initial begin
        logic [10:0] bits;
        logic [7:0]  b;
        int d0, e0, t0, f0, n;
        bit ack, ack2;

        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] bits;
        logic [7:0]  b;
        int d0, e0, t0, f0, n;
        bit ack, ack2;

        repeat (3) @(negedge clk);
        check("reset_outs",
              {25'd0, tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit,
               done, err, err_timeout}, 32'h40);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xED acknowledged; also inhibit and start-hold lengths
        run_frame(8'hED, 1'b1, 1'b0, 20);
        check("inhibit_len", inh_len, INH);
        check("start_hold_len", hold_len, HOLD);

        // 0xFF refused by the device
        run_frame(8'hFF, 1'b0, 1'b0, 18);

        // 0x00 with a silent device: timeout after clk release
        d0 = done_cnt;
        e0 = err_cnt;
        t0 = errto_cnt;
        send(8'h00);
        device_xfer(20, 1'b0, 1'b0, 0, bits);
        settle(d0, e0);
        check("to_err", err_cnt - e0, 32'd1);
        check("to_flag", errto_cnt - t0, 32'd1);
        check("to_done", done_cnt - d0, 32'd0);
        check("to_latency", err_cyc - rel_cyc, TO);
        check("to_lines", err_oe, 32'd0);

        // Reset while bit 4 of 0xF4 is on the line
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hF4);
        device_xfer(15, 1'b1, 1'b1, 5, bits);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
        dev_clk_low = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid_pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);
        run_frame(8'hF4, 1'b1, 1'b0, 15);

        // tx_valid held high across two frames (0xED then 0x02)
        d0 = done_cnt;
        e0 = err_cnt;
        f0 = frames;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hED;
        @(negedge clk);
        tx_data  = 8'h02;
        device_xfer(16, 1'b1, 1'b1, 0, bits);
        check("hold_bits0", {21'd0, bits}, {21'd0, frame_of(8'hED)});
        n = 0;
        while (tx_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("hold_reaccept", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        device_xfer(16, 1'b1, 1'b1, 0, bits);
        check("hold_bits1", {21'd0, bits}, {21'd0, frame_of(8'h02)});
        settle(d0 + 1, e0);
        check("hold_done", done_cnt - d0, 32'd2);
        check("hold_err", err_cnt - e0, 32'd0);
        check("hold_frames", frames - f0, 32'd2);
        check("hold_gap", last_gap, 32'd1);

        // Random bytes, device speeds and ACK/NACK answers
        for (int i = 0; i < 8; i++) begin
            b    = 8'($urandom_range(0, 255));
            ack  = ($urandom_range(0, 3) != 0);
            ack2 = ($urandom_range(0, 1) != 0);
            run_frame(b, ack, ack2, $urandom_range(12, 25));
            repeat ($urandom_range(1, 10)) @(negedge clk);
        end

        check("rx_inhibit_cover", inh_viol, 32'd0);
        check("done_err_overlap", both_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
